mul_datapath: RTL and testbench

MUL_DATAPATH -- requirements
Module: mul_datapath

---
 rtl/mul_datapath_if.sv | 28 ++
 rtl/mul_datapath.sv | 76 +++++++
 tb/tb_mul_datapath.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mul_datapath_if.sv
// Control/status bundle between a shift-add controller and the multiply datapath.
interface mul_datapath_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned PW = 32
);
    logic [W-1:0]  data_in;
    logic          LdA;
    logic          LdB;
    logic          LdP;
    logic          clrP;
    logic          decB;
    logic          eqz;
    logic [PW-1:0] product;
    logic          ovf;
    logic          err;

    // Controller side: drives operands and control levels, observes status.
    modport master (
        output data_in, LdA, LdB, LdP, clrP, decB,
        input  eqz, product, ovf, err
    );

    // Datapath side.
    modport slave (
        input  data_in, LdA, LdB, LdP, clrP, decB,
        output eqz, product, ovf, err
    );
endinterface

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: A/B operand registers, P accumulator,
// sticky overflow and illegal-control flags.
module mul_datapath #(
    parameter int unsigned W  = 16,
    parameter int unsigned PW = 32
) (
    input  logic          clk,
    input  logic          rst,
    mul_datapath_if.slave bus
);
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [PW-1:0] p_q, p_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          b_nz;
    logic [PW:0]   sum;

    // Next-state: loads, gated decrement/accumulate, sticky flags.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        ovf_d = ovf_q;
        err_d = err_q;
        b_nz  = (b_q != '0);
        sum   = {1'b0, p_q} + (PW + 1)'(a_q);

        if (bus.LdA) begin
            a_d = bus.data_in;
        end

        if (bus.LdB) begin
            b_d = bus.data_in;
        end else if (bus.decB && b_nz) begin
            b_d = b_q - W'(1);
        end

        // Accumulate is gated on the pre-edge B so the trailing LdP issued
        // while the controller samples eqz does not add an extra A.
        if (bus.clrP) begin
            p_d = '0;
        end else if (bus.LdP && b_nz) begin
            p_d = sum[PW-1:0];
            if (sum[PW]) begin
                ovf_d = 1'b1;
            end
        end

        if ((bus.LdB && bus.decB) || (bus.clrP && bus.LdP)) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign bus.eqz     = (b_q == '0);
    assign bus.product = p_q;
    assign bus.ovf     = ovf_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mul_datapath.sv
// Directed bench for mul_datapath: a 16x32 instance and an 8x8 instance.
module tb_mul_datapath;
    logic clk;
    logic rst16;
    logic rst8;
    int   tests;
    int   fails;

    mul_datapath_if #(.W(16), .PW(32)) i16 ();
    mul_datapath_if #(.W(8),  .PW(8))  i8  ();

    mul_datapath #(.W(16), .PW(32)) dut16 (.clk(clk), .rst(rst16), .bus(i16.slave));
    mul_datapath #(.W(8),  .PW(8))  dut8  (.clk(clk), .rst(rst8),  .bus(i8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle16();
        i16.LdA = 0; i16.LdB = 0; i16.LdP = 0; i16.clrP = 0; i16.decB = 0;
    endtask

    task automatic idle8();
        i8.LdA = 0; i8.LdB = 0; i8.LdP = 0; i8.clrP = 0; i8.decB = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        i16.data_in = '0;
        i8.data_in  = '0;
        idle16();
        idle8();
        rst16 = 1'b1;
        rst8  = 1'b1;
        #2;
        step();
        rst16 = 1'b0;
        rst8  = 1'b0;
        check("rst_product", i16.product, 0);
        check("rst_eqz",     32'(i16.eqz), 1);
        check("rst_ovf",     32'(i16.ovf), 0);
        check("rst_err",     32'(i16.err), 0);

        // 17 * 5 with two trailing accumulate cycles
        i16.LdA = 1; i16.data_in = 17; step();
        idle16(); i16.LdB = 1; i16.clrP = 1; i16.data_in = 5; step();
        check("m17x5_eqz_loaded", 32'(i16.eqz), 0);
        idle16(); i16.LdP = 1; i16.decB = 1;
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("m17x5_p%0d", i), i16.product, 32'(17 * ((i < 5) ? i : 5)));
            check($sformatf("m17x5_z%0d", i), 32'(i16.eqz), (i >= 5) ? 1 : 0);
        end
        check("m17x5_ovf", 32'(i16.ovf), 0);
        check("m17x5_err", 32'(i16.err), 0);

        // 9 * 0
        idle16(); i16.LdA = 1; i16.data_in = 9; step();
        idle16(); i16.LdB = 1; i16.clrP = 1; i16.data_in = 0; step();
        check("m9x0_eqz_loaded", 32'(i16.eqz), 1);
        idle16(); i16.LdP = 1; i16.decB = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("m9x0_p%0d", i), i16.product, 0);
            check($sformatf("m9x0_z%0d", i), 32'(i16.eqz), 1);
        end
        check("m9x0_err", 32'(i16.err), 0);

        // Build P=30, then clrP+LdP conflict
        idle16(); i16.LdA = 1; i16.data_in = 10; step();
        idle16(); i16.LdB = 1; i16.clrP = 1; i16.data_in = 3; step();
        idle16(); i16.LdP = 1; i16.decB = 1;
        repeat (3) step();
        idle16();
        check("p30", i16.product, 30);
        check("p30_err", 32'(i16.err), 0);
        i16.clrP = 1; i16.LdP = 1; step();
        idle16();
        check("clr_ld_product", i16.product, 0);
        check("clr_ld_err", 32'(i16.err), 1);
        // LdB+decB conflict: load wins, B=4 confirmed by 4 accumulates of A=10
        i16.LdB = 1; i16.decB = 1; i16.data_in = 4; step();
        idle16();
        check("ldb_dec_err", 32'(i16.err), 1);
        check("ldb_dec_eqz", 32'(i16.eqz), 0);
        i16.LdP = 1; i16.decB = 1;
        repeat (3) step();
        check("b4_eqz_after3", 32'(i16.eqz), 0);
        repeat (2) step();
        idle16();
        check("b4_product", i16.product, 40);
        check("b4_eqz", 32'(i16.eqz), 1);
        check("b4_err_sticky", 32'(i16.err), 1);

        // Reset mid-accumulation
        i16.LdA = 1; i16.data_in = 17; step();
        idle16(); i16.LdB = 1; i16.clrP = 1; i16.data_in = 5; step();
        idle16(); i16.LdP = 1; i16.decB = 1;
        repeat (2) step();
        check("mid_product", i16.product, 34);
        check("mid_eqz", 32'(i16.eqz), 0);
        rst16 = 1'b1; step();
        rst16 = 1'b0;
        idle16();
        check("mid_rst_product", i16.product, 0);
        check("mid_rst_eqz", 32'(i16.eqz), 1);
        check("mid_rst_ovf", 32'(i16.ovf), 0);
        check("mid_rst_err", 32'(i16.err), 0);
        // A must be zero after reset: accumulating adds nothing
        i16.LdB = 1; i16.clrP = 1; i16.data_in = 3; step();
        idle16(); i16.LdP = 1; step();
        idle16();
        check("rst_a_zero", i16.product, 0);
        i16.LdA = 1; i16.data_in = 6; step();
        idle16(); i16.LdB = 1; i16.clrP = 1; i16.data_in = 7; step();
        idle16(); i16.LdP = 1; i16.decB = 1;
        repeat (8) step();
        idle16();
        check("m6x7_product", i16.product, 42);
        check("m6x7_eqz", 32'(i16.eqz), 1);

        // decB alone from B=2: 1,0,0,0 with P untouched
        i16.LdB = 1; i16.data_in = 2; step();
        idle16(); i16.decB = 1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("dec_z%0d", i), 32'(i16.eqz), (i >= 2) ? 1 : 0);
            check($sformatf("dec_p%0d", i), i16.product, 42);
        end
        idle16();
        check("dec_err", 32'(i16.err), 0);

        // 8x8 overflow: 200 * 2 = 400 -> 144
        i8.LdA = 1; i8.data_in = 200; step();
        idle8(); i8.LdB = 1; i8.clrP = 1; i8.data_in = 2; step();
        idle8(); i8.LdP = 1; i8.decB = 1;
        step();
        check("w8_p1", 32'(i8.product), 200);
        check("w8_ovf1", 32'(i8.ovf), 0);
        step();
        check("w8_p2", 32'(i8.product), 144);
        check("w8_ovf2", 32'(i8.ovf), 1);
        step();
        idle8();
        check("w8_p_hold", 32'(i8.product), 144);
        i8.clrP = 1; step();
        idle8();
        check("w8_clr_product", 32'(i8.product), 0);
        check("w8_ovf_sticky", 32'(i8.ovf), 1);
        check("w8_err", 32'(i8.err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
